// File: rtl/us_pkg.sv
// Shared constants and types for the ultrasonic burst scheduler.
package us_pkg;

  // Register selects, taken from avalon_slave_address[15:8]
  localparam logic [7:0] REG_START_TIME  = 8'h00;
  localparam logic [7:0] REG_HALF_PERIOD = 8'h01;
  localparam logic [7:0] REG_PULSE_COUNT = 8'h02;
  localparam logic [7:0] REG_CONTROL     = 8'h03;  // write CONTROL, read STATUS
  localparam logic [7:0] REG_BURST_TS    = 8'h04;
  localparam logic [7:0] REG_ECHO_TS     = 8'h05;
  localparam logic [7:0] REG_FIFO_COUNT  = 8'h06;
  localparam logic [7:0] REG_LISTEN_LEN  = 8'h07;

  typedef enum logic [1:0] {
    StIdle,
    StArmed,
    StBurst,
    StListen
  } state_e;

  // STATUS bit positions
  localparam int unsigned STAT_ARMED      = 0;
  localparam int unsigned STAT_BURSTING   = 1;
  localparam int unsigned STAT_LISTENING  = 2;
  localparam int unsigned STAT_DONE       = 3;
  localparam int unsigned STAT_FIFO_EMPTY = 4;
  localparam int unsigned STAT_FIFO_FULL  = 5;
  localparam int unsigned STAT_OVERFLOW   = 6;

  localparam logic [31:0] DEADBEEF = 32'hDEAD_BEEF;

endpackage

// File: rtl/ts_fifo.sv
// Synchronous timestamp FIFO. DEPTH must be a power of two (>= 2) so the
// pointers wrap naturally.
module ts_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 8,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  localparam logic [AW-1:0] PtrOne  = AW'(1);
  localparam logic [AW:0]   CntOne  = (AW + 1)'(1);
  localparam logic [AW:0]   CntFull = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign full     = (count_q == CntFull);
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign pop_data = mem_q[rd_ptr_q];

  // A pop frees a slot in the same cycle, so push-while-full succeeds when popping
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Storage, pointers and occupancy
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= wr_ptr_q + PtrOne;
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + PtrOne;
      if (do_push && !do_pop)      count_q <= count_q + CntOne;
      else if (do_pop && !do_push) count_q <= count_q - CntOne;
    end
  end

endmodule

// File: rtl/us_burst_scheduler.sv
// Fires an ultrasonic burst at an absolute RTC time, then listens for echoes
// and timestamps their rising edges into a FIFO readable over Avalon-MM.
module us_burst_scheduler
  import us_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH          = 8,
  parameter int unsigned DEFAULT_HALF_PERIOD = 625
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] rtc_time,
  input  logic        echo_in,
  output logic        us_drive,
  output logic        us_enable,
  output logic        burst_done_irq,
  input  logic [15:0] avalon_slave_address,
  input  logic        avalon_slave_write,
  input  logic [31:0] avalon_slave_writedata,
  input  logic        avalon_slave_read,
  output logic [31:0] avalon_slave_readdata,
  output logic        avalon_slave_waitrequest
);

  localparam int unsigned FifoAw    = $clog2(FIFO_DEPTH);
  localparam logic [15:0] HalfReset = 16'(DEFAULT_HALF_PERIOD);

  // Programmed registers and their armed shadows
  logic [31:0] start_time_q, listen_len_q, start_sh_q, listen_sh_q;
  logic [15:0] half_period_q, pulse_count_q, half_sh_q, pulse_sh_q;
  // Working counters
  logic [15:0] hp_cnt_q;
  logic [16:0] pulse_cnt_q;
  logic [31:0] listen_cnt_q, burst_ts_q;
  logic        drive_q, enable_q, irq_q, done_q, overflow_q;
  state_e      state_q, state_d;
  logic        enter_burst, enter_listen, finish_listen;

  logic [7:0]  reg_sel;
  logic        ctrl_wr, arm_req, abort_req, arm_go;
  logic [15:0] half_eff;
  logic [31:0] listen_eff, time_diff, status, rd_mux, readdata_q;
  logic        waitflag_q, rd_capture, rd_pop;

  logic        sync1_q, sync2_q, sync3_q, edge_q, echo_push;
  logic [31:0] fifo_rdata;
  logic        fifo_full, fifo_empty;
  logic [FifoAw:0] fifo_count;

  assign reg_sel   = avalon_slave_address[15:8];
  assign ctrl_wr   = avalon_slave_write && (reg_sel == REG_CONTROL);
  assign abort_req = ctrl_wr && avalon_slave_writedata[1];
  assign arm_req   = ctrl_wr && avalon_slave_writedata[0] && !avalon_slave_writedata[1];
  assign arm_go    = arm_req && (state_q == StIdle);

  assign half_eff   = (half_sh_q == '0) ? 16'd1 : half_sh_q;
  assign listen_eff = (listen_sh_q == '0) ? 32'd1 : listen_sh_q;
  // Wrap-aware "start time reached": difference is non-negative as a signed value
  assign time_diff  = rtc_time - start_sh_q;

  // Register file writes and shadow capture on arm
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      start_time_q  <= '0;
      half_period_q <= HalfReset;
      pulse_count_q <= '0;
      listen_len_q  <= '0;
      start_sh_q    <= '0;
      half_sh_q     <= '0;
      pulse_sh_q    <= '0;
      listen_sh_q   <= '0;
    end else begin
      if (avalon_slave_write) begin
        case (reg_sel)
          REG_START_TIME:  start_time_q  <= avalon_slave_writedata;
          REG_HALF_PERIOD: half_period_q <= avalon_slave_writedata[15:0];
          REG_PULSE_COUNT: pulse_count_q <= avalon_slave_writedata[15:0];
          REG_LISTEN_LEN:  listen_len_q  <= avalon_slave_writedata;
          default: ;
        endcase
      end
      if (arm_go) begin
        start_sh_q  <= start_time_q;
        half_sh_q   <= half_period_q;
        pulse_sh_q  <= pulse_count_q;
        listen_sh_q <= listen_len_q;
      end
    end
  end

  // FSM state register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // FSM next state and phase-transition strobes
  always_comb begin
    state_d       = state_q;
    enter_burst   = 1'b0;
    enter_listen  = 1'b0;
    finish_listen = 1'b0;
    unique case (state_q)
      StIdle: if (arm_req) state_d = StArmed;
      StArmed: begin
        if (!time_diff[31]) begin
          state_d     = StBurst;
          enter_burst = 1'b1;
        end
      end
      StBurst: begin
        if (hp_cnt_q == '0 && pulse_cnt_q == '0) begin
          state_d      = StListen;
          enter_listen = 1'b1;
        end
      end
      StListen: begin
        if (listen_cnt_q == '0) begin
          state_d       = StIdle;
          finish_listen = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
    if (abort_req) begin
      state_d       = StIdle;
      enter_burst   = 1'b0;
      enter_listen  = 1'b0;
      finish_listen = 1'b0;
    end
  end

  // Burst waveform generation and phase counters
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hp_cnt_q     <= '0;
      pulse_cnt_q  <= '0;
      listen_cnt_q <= '0;
      burst_ts_q   <= '0;
      drive_q      <= 1'b0;
      enable_q     <= 1'b0;
    end else begin
      if (enter_burst) begin
        burst_ts_q <= rtc_time;
        enable_q   <= 1'b1;
        if (pulse_sh_q == '0) begin
          // Zero pulses: one silent BURST cycle
          drive_q     <= 1'b0;
          hp_cnt_q    <= '0;
          pulse_cnt_q <= '0;
        end else begin
          drive_q     <= 1'b1;
          hp_cnt_q    <= half_eff - 16'd1;
          pulse_cnt_q <= {pulse_sh_q, 1'b0} - 17'd1;
        end
      end else if (state_q == StBurst) begin
        if (enter_listen) begin
          drive_q      <= 1'b0;
          enable_q     <= 1'b0;
          listen_cnt_q <= listen_eff - 32'd1;
        end else if (hp_cnt_q == '0) begin
          drive_q     <= ~drive_q;
          pulse_cnt_q <= pulse_cnt_q - 17'd1;
          hp_cnt_q    <= half_eff - 16'd1;
        end else begin
          hp_cnt_q <= hp_cnt_q - 16'd1;
        end
      end else if (state_q == StListen) begin
        listen_cnt_q <= listen_cnt_q - 32'd1;
      end
      if (abort_req) begin
        drive_q  <= 1'b0;
        enable_q <= 1'b0;
      end
    end
  end

  // Completion pulse and sticky done/overflow flags
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      irq_q      <= 1'b0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      irq_q <= finish_listen;
      if (arm_go)             done_q <= 1'b0;
      else if (finish_listen) done_q <= 1'b1;
      if (arm_go)                                          overflow_q <= 1'b0;
      else if (echo_push && fifo_full && !(rd_pop && !fifo_empty)) overflow_q <= 1'b1;
    end
  end

  // Echo pin synchronizer and registered rising-edge detect
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      sync3_q <= 1'b0;
      edge_q  <= 1'b0;
    end else begin
      sync1_q <= echo_in;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
      edge_q  <= sync2_q && !sync3_q;
    end
  end

  assign echo_push = edge_q && (state_q == StBurst || state_q == StListen);

  ts_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_ts_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (echo_push),
    .push_data (rtc_time),
    .pop       (rd_pop),
    .pop_data  (fifo_rdata),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // STATUS word assembly
  always_comb begin
    status                  = '0;
    status[STAT_ARMED]      = (state_q == StArmed);
    status[STAT_BURSTING]   = (state_q == StBurst);
    status[STAT_LISTENING]  = (state_q == StListen);
    status[STAT_DONE]       = done_q;
    status[STAT_FIFO_EMPTY] = fifo_empty;
    status[STAT_FIFO_FULL]  = fifo_full;
    status[STAT_OVERFLOW]   = overflow_q;
  end

  // Read data selection
  always_comb begin
    rd_mux = DEADBEEF;
    case (reg_sel)
      REG_START_TIME:  rd_mux = start_time_q;
      REG_HALF_PERIOD: rd_mux = {16'h0000, half_period_q};
      REG_PULSE_COUNT: rd_mux = {16'h0000, pulse_count_q};
      REG_CONTROL:     rd_mux = status;
      REG_BURST_TS:    rd_mux = burst_ts_q;
      REG_ECHO_TS:     rd_mux = fifo_empty ? DEADBEEF : fifo_rdata;
      REG_FIFO_COUNT:  rd_mux = 32'(fifo_count);
      REG_LISTEN_LEN:  rd_mux = listen_len_q;
      default:         rd_mux = DEADBEEF;
    endcase
  end

  // First read cycle captures data; the second (waitrequest low) completes and pops
  assign rd_capture = avalon_slave_read && waitflag_q;
  assign rd_pop     = avalon_slave_read && !waitflag_q && (reg_sel == REG_ECHO_TS);

  // Read-side handshake state and registered read data
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      waitflag_q <= 1'b1;
      readdata_q <= '0;
    end else begin
      waitflag_q <= !rd_capture;
      if (rd_capture) readdata_q <= rd_mux;
    end
  end

  assign avalon_slave_waitrequest = !reset || (avalon_slave_read && waitflag_q);
  assign avalon_slave_readdata    = readdata_q;
  assign us_drive                 = drive_q;
  assign us_enable                = enable_q;
  assign burst_done_irq           = irq_q;

endmodule

// File: tb/tb_us_burst_scheduler.sv
// Directed bench for us_burst_scheduler.
module tb_us_burst_scheduler;

  localparam logic [7:0] A_START  = 8'h00;
  localparam logic [7:0] A_HALF   = 8'h01;
  localparam logic [7:0] A_PULSE  = 8'h02;
  localparam logic [7:0] A_CTRL   = 8'h03;
  localparam logic [7:0] A_BTS    = 8'h04;
  localparam logic [7:0] A_ECHO   = 8'h05;
  localparam logic [7:0] A_COUNT  = 8'h06;
  localparam logic [7:0] A_LISTEN = 8'h07;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] rtc_time = 32'd0;
  logic        rtc_load = 1'b0;
  logic [31:0] rtc_load_val = 32'd0;
  logic        echo_in = 1'b0;
  logic        us_drive, us_enable, burst_done_irq;
  logic [15:0] address = 16'd0;
  logic        write = 1'b0;
  logic [31:0] writedata = 32'd0;
  logic        read = 1'b0;
  logic [31:0] readdata;
  logic        waitrequest;

  int vectors = 0;
  int miscompares = 0;

  us_burst_scheduler dut (
    .clock                    (clock),
    .reset                    (reset),
    .rtc_time                 (rtc_time),
    .echo_in                  (echo_in),
    .us_drive                 (us_drive),
    .us_enable                (us_enable),
    .burst_done_irq           (burst_done_irq),
    .avalon_slave_address     (address),
    .avalon_slave_write       (write),
    .avalon_slave_writedata   (writedata),
    .avalon_slave_read        (read),
    .avalon_slave_readdata    (readdata),
    .avalon_slave_waitrequest (waitrequest)
  );

  always #10 clock = ~clock;

  // Free-running RTC model, loadable for wrap and late-arm scenarios
  always @(posedge clock) rtc_time <= rtc_load ? rtc_load_val : rtc_time + 32'd1;

  task automatic load_rtc(input logic [31:0] v);
    @(negedge clock);
    rtc_load = 1'b1;
    rtc_load_val = v;
    @(negedge clock);
    rtc_load = 1'b0;
  endtask

  task automatic bus_write(input logic [7:0] sel, input logic [31:0] data);
    @(negedge clock);
    address = {sel, 8'h00};
    writedata = data;
    write = 1'b1;
    @(negedge clock);
    write = 1'b0;
  endtask

  task automatic bus_read(input logic [7:0] sel, output logic [31:0] data);
    int n;
    @(negedge clock);
    address = {sel, 8'h00};
    read = 1'b1;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (waitrequest !== 1'b0 && n < 8);
    if (waitrequest !== 1'b0) begin
      vectors++;
      miscompares++;
      $display("FAIL read_timeout sel=%h: waitrequest stuck at %b, required 0", sel, waitrequest);
    end
    data = readdata;
    @(negedge clock);
    read = 1'b0;
  endtask

  task automatic wait_rtc(input logic [31:0] v);
    int n = 0;
    while (rtc_time !== v && n < 200) begin
      @(negedge clock);
      n++;
    end
  endtask

  task automatic wait_enable(input string name);
    int n = 0;
    while (us_enable !== 1'b1 && n < 200) begin
      @(negedge clock);
      n++;
    end
    vectors++;
    if (us_enable !== 1'b1) begin
      miscompares++;
      $display("FAIL %s_enable_timeout: us_enable=%b, required 1", name, us_enable);
    end
  endtask

  task automatic wait_irq(input string name, input int budget);
    int n = 0;
    while (burst_done_irq !== 1'b1 && n < budget) begin
      @(negedge clock);
      n++;
    end
    vectors++;
    if (burst_done_irq !== 1'b1) begin
      miscompares++;
      $display("FAIL %s_irq_timeout: burst_done_irq=%b, required 1", name, burst_done_irq);
    end
  endtask

  task automatic test_reset();
    logic [31:0] d;
    repeat (3) @(negedge clock);
    vectors++;
    if ({us_drive, us_enable, burst_done_irq, waitrequest} !== 4'b0001 || readdata !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: drv/en/irq/wait=%b%b%b%b rd=%h, required 0001 rd=0",
               us_drive, us_enable, burst_done_irq, waitrequest, readdata);
    end
    reset = 1'b1;
    bus_read(A_CTRL, d);
    vectors++;
    if (d !== 32'h10) begin
      miscompares++;
      $display("FAIL reset_status: got %h, required 00000010", d);
    end
    bus_read(A_HALF, d);
    vectors++;
    if (d !== 32'd625) begin
      miscompares++;
      $display("FAIL reset_half_period: got %0d, required 625", d);
    end
    bus_read(A_COUNT, d);
    vectors++;
    if (d !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_fifo_count: got %0d, required 0", d);
    end
  endtask

  task automatic test_registers();
    logic [31:0] d;
    bus_write(A_HALF, 32'h1234_5678);
    bus_read(A_HALF, d);
    vectors++;
    if (d !== 32'h0000_5678) begin
      miscompares++;
      $display("FAIL reg_half_width: got %h, required 00005678", d);
    end
    bus_write(A_LISTEN, 32'hCAFE_F00D);
    bus_write(8'h09, 32'h1111_1111);
    bus_read(A_LISTEN, d);
    vectors++;
    if (d !== 32'hCAFE_F00D) begin
      miscompares++;
      $display("FAIL reg_listen_len: got %h, required cafef00d", d);
    end
    bus_read(8'h09, d);
    vectors++;
    if (d !== 32'hDEAD_BEEF) begin
      miscompares++;
      $display("FAIL reg_unmapped: got %h, required deadbeef", d);
    end
    // Arm together with abort must leave the block idle
    bus_write(A_CTRL, 32'h3);
    bus_read(A_CTRL, d);
    vectors++;
    if (d !== 32'h10) begin
      miscompares++;
      $display("FAIL arm_abort_same_write: status %h, required 00000010", d);
    end
  endtask

  task automatic test_basic_burst();
    logic [31:0] d;
    logic [2:0]  exp_sig;
    int          irqs = 0;
    load_rtc(32'd880);
    bus_write(A_START, 32'd1000);
    bus_write(A_HALF, 32'd5);
    bus_write(A_PULSE, 32'd3);
    bus_write(A_LISTEN, 32'd10);
    wait_rtc(32'd899);
    bus_write(A_CTRL, 32'h1);
    bus_read(A_CTRL, d);
    vectors++;
    if (d !== 32'h11) begin
      miscompares++;
      $display("FAIL basic_armed_status: got %h, required 00000011", d);
    end
    wait_enable("basic");
    vectors++;
    if (rtc_time !== 32'd1001) begin
      miscompares++;
      $display("FAIL basic_enable_time: enable seen at rtc %0d, required 1001", rtc_time);
    end
    // k counts cycles from the first enabled cycle: 30 burst, 10 listen, then irq
    for (int k = 0; k < 46; k++) begin
      exp_sig[2] = (k < 30);
      exp_sig[1] = (k < 30) && (((k / 5) % 2) == 0);
      exp_sig[0] = (k == 40);
      if (burst_done_irq === 1'b1) irqs++;
      vectors++;
      if ({us_enable, us_drive, burst_done_irq} !== exp_sig) begin
        miscompares++;
        $display("FAIL basic_wave k=%0d: en/drv/irq=%b%b%b, required %b",
                 k, us_enable, us_drive, burst_done_irq, exp_sig);
      end
      @(negedge clock);
    end
    vectors++;
    if (irqs != 1) begin
      miscompares++;
      $display("FAIL basic_irq_count: got %0d pulses, required 1", irqs);
    end
    bus_read(A_BTS, d);
    vectors++;
    if (d !== 32'd1000) begin
      miscompares++;
      $display("FAIL basic_burst_ts: got %0d, required 1000", d);
    end
    bus_read(A_CTRL, d);
    vectors++;
    if (d !== 32'h18) begin
      miscompares++;
      $display("FAIL basic_done_status: got %h, required 00000018", d);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] d;
    load_rtc(32'hFFFF_FFE0);
    bus_write(A_START, 32'h0000_0010);
    bus_write(A_PULSE, 32'd0);
    bus_write(A_LISTEN, 32'd0);
    wait_rtc(32'hFFFF_FFEF);
    bus_write(A_CTRL, 32'h1);
    bus_read(A_CTRL, d);
    vectors++;
    if (d !== 32'h11) begin
      miscompares++;
      $display("FAIL wrap_not_immediate: status %h, required 00000011", d);
    end
    wait_enable("wrap");
    vectors++;
    if (rtc_time !== 32'h11 || us_drive !== 1'b0) begin
      miscompares++;
      $display("FAIL wrap_fire: rtc %h drive %b, required rtc 00000011 drive 0", rtc_time, us_drive);
    end
    bus_read(A_BTS, d);
    vectors++;
    if (d !== 32'h10) begin
      miscompares++;
      $display("FAIL wrap_burst_ts: got %h, required 00000010", d);
    end
  endtask

  task automatic test_late_arm();
    logic [31:0] d;
    load_rtc(32'd4990);
    bus_write(A_START, 32'd100);
    wait_rtc(32'd4999);
    bus_write(A_CTRL, 32'h1);
    vectors++;
    if (us_enable !== 1'b0) begin
      miscompares++;
      $display("FAIL late_enable_early: us_enable=%b, required 0", us_enable);
    end
    @(negedge clock);
    vectors++;
    if (us_enable !== 1'b1 || rtc_time !== 32'd5002) begin
      miscompares++;
      $display("FAIL late_fire: enable %b at rtc %0d, required 1 at 5002", us_enable, rtc_time);
    end
    bus_read(A_BTS, d);
    vectors++;
    if (d !== 32'd5001) begin
      miscompares++;
      $display("FAIL late_burst_ts: got %0d, required 5001", d);
    end
  endtask

  task automatic test_echo_overflow();
    logic [31:0] d;
    logic [31:0] stamps [9];
    bus_write(A_START, 32'd0);
    bus_write(A_LISTEN, 32'd300);
    bus_write(A_CTRL, 32'h1);
    repeat (4) @(negedge clock);
    for (int i = 0; i < 9; i++) begin
      @(negedge clock);
      echo_in = 1'b1;
      stamps[i] = rtc_time;
      repeat (2) @(negedge clock);
      echo_in = 1'b0;
      repeat (3) @(negedge clock);
    end
    wait_irq("echo", 400);
    bus_read(A_COUNT, d);
    vectors++;
    if (d !== 32'd8) begin
      miscompares++;
      $display("FAIL echo_fifo_count: got %0d, required 8", d);
    end
    bus_read(A_CTRL, d);
    vectors++;
    if (d !== 32'h68) begin
      miscompares++;
      $display("FAIL echo_status_full: got %h, required 00000068", d);
    end
    for (int i = 0; i < 8; i++) begin
      bus_read(A_ECHO, d);
      vectors++;
      if (d !== stamps[i] + 32'd3) begin
        miscompares++;
        $display("FAIL echo_ts[%0d]: got %0d, required %0d", i, d, stamps[i] + 32'd3);
      end
    end
    bus_read(A_ECHO, d);
    vectors++;
    if (d !== 32'hDEAD_BEEF) begin
      miscompares++;
      $display("FAIL echo_pop_empty: got %h, required deadbeef", d);
    end
    bus_read(A_COUNT, d);
    vectors++;
    if (d !== 32'd0) begin
      miscompares++;
      $display("FAIL echo_count_after_drain: got %0d, required 0", d);
    end
  endtask

  task automatic test_abort_rearm();
    logic [31:0] d;
    logic [1:0]  exp_sig;
    bus_write(A_HALF, 32'd5);
    bus_write(A_PULSE, 32'd100);
    bus_write(A_LISTEN, 32'd5);
    bus_write(A_CTRL, 32'h1);
    repeat (20) @(negedge clock);
    vectors++;
    if (us_enable !== 1'b1) begin
      miscompares++;
      $display("FAIL abort_pre_enable: us_enable=%b, required 1", us_enable);
    end
    bus_write(A_CTRL, 32'h2);
    vectors++;
    if ({us_enable, us_drive} !== 2'b00) begin
      miscompares++;
      $display("FAIL abort_outputs: en/drv=%b%b, required 00", us_enable, us_drive);
    end
    bus_read(A_CTRL, d);
    vectors++;
    if (d !== 32'h10) begin
      miscompares++;
      $display("FAIL abort_status: got %h, required 00000010", d);
    end
    bus_write(A_HALF, 32'd2);
    bus_write(A_PULSE, 32'd1);
    bus_write(A_LISTEN, 32'd0);
    bus_write(A_CTRL, 32'h1);
    wait_enable("rearm");
    for (int k = 0; k < 5; k++) begin
      exp_sig = {(k < 4), (k < 2)};
      vectors++;
      if ({us_enable, us_drive} !== exp_sig) begin
        miscompares++;
        $display("FAIL rearm_wave k=%0d: en/drv=%b%b, required %b", k, us_enable, us_drive, exp_sig);
      end
      @(negedge clock);
    end
    wait_irq("rearm", 20);
    bus_read(A_CTRL, d);
    vectors++;
    if (d !== 32'h18) begin
      miscompares++;
      $display("FAIL rearm_status: got %h, required 00000018", d);
    end
  endtask

  task automatic test_reset_mid_burst();
    logic [31:0] d;
    bus_write(A_HALF, 32'd5);
    bus_write(A_PULSE, 32'd100);
    bus_write(A_CTRL, 32'h1);
    repeat (15) @(negedge clock);
    vectors++;
    if (us_enable !== 1'b1) begin
      miscompares++;
      $display("FAIL midreset_pre_enable: us_enable=%b, required 1", us_enable);
    end
    reset = 1'b0;
    #1;
    vectors++;
    if ({us_drive, us_enable, waitrequest} !== 3'b001 || readdata !== 32'd0) begin
      miscompares++;
      $display("FAIL midreset_outputs: drv/en/wait=%b%b%b rd=%h, required 001 rd=0",
               us_drive, us_enable, waitrequest, readdata);
    end
    repeat (2) @(negedge clock);
    reset = 1'b1;
    bus_read(A_CTRL, d);
    vectors++;
    if (d !== 32'h10) begin
      miscompares++;
      $display("FAIL midreset_status: got %h, required 00000010", d);
    end
    bus_read(A_HALF, d);
    vectors++;
    if (d !== 32'd625) begin
      miscompares++;
      $display("FAIL midreset_half_period: got %0d, required 625", d);
    end
  endtask

  initial begin
    test_reset();
    test_registers();
    test_basic_burst();
    test_wrap();
    test_late_arm();
    test_echo_overflow();
    test_abort_rearm();
    test_reset_mid_burst();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
